// File: rtl/hazard_sb_if.sv
// hazard_sb_if: bundles the decode-side hazard query, producer-stage status,
// mult/div scoreboard control and the hazard unit's responses.
//   master : pipeline side, drives decode/stage/MD/flush/perf inputs
//   slave  : hazard unit, returns forward selects, stall, md_busy, stall_cnt
interface hazard_sb_if #(
  parameter int NSTG = 3,
  parameter int AW   = 5,
  parameter int CNTW = 32
);
  localparam int FW = $clog2(NSTG + 1);

  logic               ds_use_rs;
  logic [AW-1:0]      ds_rs_addr;
  logic               ds_use_rt;
  logic [AW-1:0]      ds_rt_addr;
  logic               ds_hilo_rd;
  logic               ds_md_op;
  logic [NSTG-1:0]    st_write_reg;
  logic [NSTG*AW-1:0] st_reg_dest;
  logic [NSTG-1:0]    st_data_ok;
  logic [NSTG-1:0]    st_ex;
  logic               md_start;
  logic               md_is_div;
  logic               flush;
  logic               perf_clr;
  logic [FW-1:0]      forward_rs;
  logic [FW-1:0]      forward_rt;
  logic               stall_d;
  logic               md_busy;
  logic [CNTW-1:0]    stall_cnt;

  modport master (
    output ds_use_rs, ds_rs_addr, ds_use_rt, ds_rt_addr, ds_hilo_rd, ds_md_op,
           st_write_reg, st_reg_dest, st_data_ok, st_ex,
           md_start, md_is_div, flush, perf_clr,
    input  forward_rs, forward_rt, stall_d, md_busy, stall_cnt
  );

  modport slave (
    input  ds_use_rs, ds_rs_addr, ds_use_rt, ds_rt_addr, ds_hilo_rd, ds_md_op,
           st_write_reg, st_reg_dest, st_data_ok, st_ex,
           md_start, md_is_div, flush, perf_clr,
    output forward_rs, forward_rt, stall_d, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_sb.sv
// hazard_sb: hazard/forwarding unit for the in-order MIPS pipeline.
// Compares decode source registers against NSTG producer stages (0 = EXE,
// NSTG-1 = WB), picks a bypass source or requests a decode stall, tracks a
// mult/div busy scoreboard for HI/LO hazards and counts stall cycles.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : synchronous, active-high
//   hz    : hazard_sb_if.slave (decode query, stage status, MD control,
//           forward_rs/forward_rt, stall_d, md_busy, stall_cnt)
module hazard_sb #(
  parameter int NSTG    = 3,
  parameter int AW      = 5,
  parameter bit FWD_EN  = 1'b1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33,
  parameter int CNTW    = 32
) (
  input  logic        clk,
  input  logic        reset,
  hazard_sb_if.slave  hz
);
  localparam int FW = $clog2(NSTG + 1);
  localparam int MW = $clog2(DIV_LAT + 1);

  logic [NSTG-1:0] match_rs, match_rt;
  logic [FW-1:0]   fwd_rs, fwd_rt;
  logic            raw_rs, raw_rt;
  logic            md_stall;
  logic            stall;
  logic [MW-1:0]   mdc;

  always_comb begin
    match_rs = '0;
    match_rt = '0;
    for (int i = 0; i < NSTG; i++) begin
      match_rs[i] = hz.ds_use_rs && (hz.ds_rs_addr != '0) && hz.st_write_reg[i]
                    && (hz.st_reg_dest[i*AW +: AW] == hz.ds_rs_addr);
      match_rt[i] = hz.ds_use_rt && (hz.ds_rt_addr != '0) && hz.st_write_reg[i]
                    && (hz.st_reg_dest[i*AW +: AW] == hz.ds_rt_addr);
    end
  end

  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    fwd_rs = '0;
    fwd_rt = '0;
    raw_rs = 1'b0;
    raw_rt = 1'b0;
    if (FWD_EN) begin
      for (int i = NSTG - 1; i >= 0; i--) begin
        if (match_rs[i]) begin
          fwd_rs = hz.st_data_ok[i] ? FW'(NSTG - i) : '0;
          raw_rs = !hz.st_data_ok[i];
        end
        if (match_rt[i]) begin
          fwd_rt = hz.st_data_ok[i] ? FW'(NSTG - i) : '0;
          raw_rt = !hz.st_data_ok[i];
        end
      end
    end else begin
      raw_rs = |match_rs;
      raw_rt = |match_rt;
    end
  end

  assign md_stall = (hz.ds_hilo_rd || hz.ds_md_op) && (mdc != '0);
  // An in-flight exception will flush decode anyway, so never hold it.
  assign stall    = !(|hz.st_ex) && (raw_rs || raw_rt || md_stall);

  assign hz.forward_rs = fwd_rs;
  assign hz.forward_rt = fwd_rt;
  assign hz.stall_d    = stall;
  assign hz.md_busy    = (mdc != '0);

  always_ff @(posedge clk) begin
    if (reset || hz.flush) begin
      mdc <= '0;
    end else if (hz.md_start) begin
      mdc <= hz.md_is_div ? MW'(DIV_LAT) : MW'(MUL_LAT);
    end else if (mdc != '0) begin
      mdc <= mdc - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || hz.perf_clr) begin
      hz.stall_cnt <= '0;
    end else if (stall && (hz.stall_cnt != {CNTW{1'b1}})) begin
      hz.stall_cnt <= hz.stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_sb.sv
module tb_hazard_sb;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_sb_if #(.NSTG(3), .AW(5), .CNTW(32)) ia ();
  hazard_sb_if #(.NSTG(3), .AW(5), .CNTW(32)) ib ();
  hazard_sb_if #(.NSTG(3), .AW(5), .CNTW(4))  ic ();

  hazard_sb #(.NSTG(3), .AW(5), .FWD_EN(1'b1), .MUL_LAT(2), .DIV_LAT(33), .CNTW(32))
    dut_a (.clk(clk), .reset(reset), .hz(ia));
  hazard_sb #(.NSTG(3), .AW(5), .FWD_EN(1'b0), .MUL_LAT(2), .DIV_LAT(33), .CNTW(32))
    dut_b (.clk(clk), .reset(reset), .hz(ib));
  hazard_sb #(.NSTG(3), .AW(5), .FWD_EN(1'b1), .MUL_LAT(2), .DIV_LAT(33), .CNTW(4))
    dut_c (.clk(clk), .reset(reset), .hz(ic));

  task automatic clear_all();
    ia.ds_use_rs = 0; ia.ds_rs_addr = '0; ia.ds_use_rt = 0; ia.ds_rt_addr = '0;
    ia.ds_hilo_rd = 0; ia.ds_md_op = 0; ia.st_write_reg = '0; ia.st_reg_dest = '0;
    ia.st_data_ok = '0; ia.st_ex = '0; ia.md_start = 0; ia.md_is_div = 0;
    ia.flush = 0; ia.perf_clr = 0;
    ib.ds_use_rs = 0; ib.ds_rs_addr = '0; ib.ds_use_rt = 0; ib.ds_rt_addr = '0;
    ib.ds_hilo_rd = 0; ib.ds_md_op = 0; ib.st_write_reg = '0; ib.st_reg_dest = '0;
    ib.st_data_ok = '0; ib.st_ex = '0; ib.md_start = 0; ib.md_is_div = 0;
    ib.flush = 0; ib.perf_clr = 0;
    ic.ds_use_rs = 0; ic.ds_rs_addr = '0; ic.ds_use_rt = 0; ic.ds_rt_addr = '0;
    ic.ds_hilo_rd = 0; ic.ds_md_op = 0; ic.st_write_reg = '0; ic.st_reg_dest = '0;
    ic.st_data_ok = '0; ic.st_ex = '0; ic.md_start = 0; ic.md_is_div = 0;
    ic.flush = 0; ic.perf_clr = 0;
  endtask

  task automatic test_reset();
    clear_all();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    n_cmp++; if (ia.md_busy !== 1'b0) begin n_err++; $display("FAIL reset_md_busy got %0d want 0", ia.md_busy); end
    n_cmp++; if (ia.stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall_cnt got %0d want 0", ia.stall_cnt); end
    n_cmp++; if (ia.stall_d !== 1'b0) begin n_err++; $display("FAIL reset_stall_d got %0d want 0", ia.stall_d); end
    n_cmp++; if (ia.forward_rs !== 2'd0) begin n_err++; $display("FAIL reset_fwd_rs got %0d want 0", ia.forward_rs); end
  endtask

  task automatic test_forward_priority();
    @(negedge clk);
    clear_all();
    ia.ds_use_rs = 1; ia.ds_rs_addr = 5'd5;
    ia.st_write_reg = 3'b011; ia.st_reg_dest = {5'd0, 5'd5, 5'd5}; ia.st_data_ok = 3'b111;
    #1;
    n_cmp++; if (ia.forward_rs !== 2'd3) begin n_err++; $display("FAIL t1_exe_fwd got %0d want 3", ia.forward_rs); end
    n_cmp++; if (ia.stall_d !== 1'b0) begin n_err++; $display("FAIL t1_exe_stall got %0d want 0", ia.stall_d); end
    ia.st_write_reg = 3'b010;
    #1;
    n_cmp++; if (ia.forward_rs !== 2'd2) begin n_err++; $display("FAIL t1_mem_fwd got %0d want 2", ia.forward_rs); end
    ia.st_write_reg = 3'b100; ia.st_reg_dest = {5'd5, 5'd0, 5'd0};
    #1;
    n_cmp++; if (ia.forward_rs !== 2'd1) begin n_err++; $display("FAIL t1_wb_fwd got %0d want 1", ia.forward_rs); end
    // youngest match not ready while an older one is: must stall, not bypass older
    ia.st_write_reg = 3'b011; ia.st_reg_dest = {5'd0, 5'd5, 5'd5}; ia.st_data_ok = 3'b110;
    #1;
    n_cmp++; if (ia.stall_d !== 1'b1) begin n_err++; $display("FAIL t1_young_notok_stall got %0d want 1", ia.stall_d); end
    n_cmp++; if (ia.forward_rs !== 2'd0) begin n_err++; $display("FAIL t1_young_notok_fwd got %0d want 0", ia.forward_rs); end
    // rt path, distinct register from rs
    ia.st_data_ok = 3'b111;
    ia.ds_use_rt = 1; ia.ds_rt_addr = 5'd9; ia.st_write_reg = 3'b110;
    ia.st_reg_dest = {5'd9, 5'd9, 5'd5};
    #1;
    n_cmp++; if (ia.forward_rt !== 2'd2) begin n_err++; $display("FAIL t1_rt_mem_fwd got %0d want 2", ia.forward_rt); end
    n_cmp++; if (ia.forward_rs !== 2'd0) begin n_err++; $display("FAIL t1_rs_nomatch got %0d want 0", ia.forward_rs); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_all();
    ia.ds_use_rt = 1; ia.ds_rt_addr = 5'd8;
    ia.st_write_reg = 3'b001; ia.st_reg_dest = {5'd0, 5'd0, 5'd8}; ia.st_data_ok = 3'b110;
    #1;
    n_cmp++; if (ia.stall_d !== 1'b1) begin n_err++; $display("FAIL t2_load_stall got %0d want 1", ia.stall_d); end
    n_cmp++; if (ia.forward_rt !== 2'd0) begin n_err++; $display("FAIL t2_load_fwd got %0d want 0", ia.forward_rt); end
    ia.st_ex = 3'b010;
    #1;
    n_cmp++; if (ia.stall_d !== 1'b0) begin n_err++; $display("FAIL t2_ex_suppress got %0d want 0", ia.stall_d); end
  endtask

  task automatic test_zero_and_nofwd();
    @(negedge clk);
    clear_all();
    ia.ds_use_rs = 1; ia.ds_rs_addr = 5'd0;
    ia.st_write_reg = 3'b001; ia.st_reg_dest = '0; ia.st_data_ok = 3'b000;
    #1;
    n_cmp++; if (ia.forward_rs !== 2'd0) begin n_err++; $display("FAIL t3_r0_fwd got %0d want 0", ia.forward_rs); end
    n_cmp++; if (ia.stall_d !== 1'b0) begin n_err++; $display("FAIL t3_r0_stall got %0d want 0", ia.stall_d); end
    ib.ds_use_rs = 1; ib.ds_rs_addr = 5'd7;
    ib.st_write_reg = 3'b010; ib.st_reg_dest = {5'd0, 5'd7, 5'd0}; ib.st_data_ok = 3'b111;
    #1;
    n_cmp++; if (ib.stall_d !== 1'b1) begin n_err++; $display("FAIL t3_nofwd_stall got %0d want 1", ib.stall_d); end
    n_cmp++; if (ib.forward_rs !== 2'd0) begin n_err++; $display("FAIL t3_nofwd_fwd got %0d want 0", ib.forward_rs); end
  endtask

  task automatic test_div_stall();
    int hi;
    @(negedge clk);
    clear_all();
    ia.perf_clr = 1;
    @(negedge clk);
    ia.perf_clr = 0; ia.md_start = 1; ia.md_is_div = 1; ia.ds_hilo_rd = 1;
    @(posedge clk);
    #1 ia.md_start = 0; ia.md_is_div = 0;
    hi = 0;
    while (ia.stall_d === 1'b1 && hi < 40) begin
      hi++;
      @(posedge clk);
      #1;
    end
    n_cmp++; if (hi != 33) begin n_err++; $display("FAIL t4_div_stall_cycles got %0d want 33", hi); end
    n_cmp++; if (ia.md_busy !== 1'b0) begin n_err++; $display("FAIL t4_busy_end got %0d want 0", ia.md_busy); end
    n_cmp++; if (ia.stall_cnt !== 32'd33) begin n_err++; $display("FAIL t4_stall_cnt got %0d want 33", ia.stall_cnt); end
  endtask

  task automatic test_flush_and_reset();
    @(negedge clk);
    clear_all();
    ia.md_start = 1; ia.md_is_div = 0; ia.flush = 1;
    @(posedge clk);
    #1 ia.md_start = 0; ia.flush = 0;
    n_cmp++; if (ia.md_busy !== 1'b0) begin n_err++; $display("FAIL t5_flush_busy got %0d want 0", ia.md_busy); end
    @(negedge clk) ia.md_start = 1; ia.ds_md_op = 1;
    @(posedge clk);
    #1 ia.md_start = 0;
    n_cmp++; if (ia.md_busy !== 1'b1) begin n_err++; $display("FAIL t5_mul_busy1 got %0d want 1", ia.md_busy); end
    n_cmp++; if (ia.stall_d !== 1'b1) begin n_err++; $display("FAIL t5_mdop_stall got %0d want 1", ia.stall_d); end
    @(posedge clk); #1;
    n_cmp++; if (ia.md_busy !== 1'b1) begin n_err++; $display("FAIL t5_mul_busy2 got %0d want 1", ia.md_busy); end
    @(posedge clk); #1;
    n_cmp++; if (ia.md_busy !== 1'b0) begin n_err++; $display("FAIL t5_mul_busy3 got %0d want 0", ia.md_busy); end
    @(negedge clk) ia.md_start = 1; ia.md_is_div = 1; ia.ds_hilo_rd = 1; ia.ds_md_op = 0;
    @(posedge clk);
    #1 ia.md_start = 0; ia.md_is_div = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ia.md_busy !== 1'b1) begin n_err++; $display("FAIL t5_div_busy got %0d want 1", ia.md_busy); end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ia.md_busy !== 1'b0) begin n_err++; $display("FAIL t5_reset_busy got %0d want 0", ia.md_busy); end
    n_cmp++; if (ia.stall_cnt !== 32'd0) begin n_err++; $display("FAIL t5_reset_cnt got %0d want 0", ia.stall_cnt); end
    @(negedge clk) reset = 1'b0;
    clear_all();
  endtask

  task automatic test_saturation();
    @(negedge clk);
    clear_all();
    ic.ds_use_rs = 1; ic.ds_rs_addr = 5'd3;
    ic.st_write_reg = 3'b001; ic.st_reg_dest = {5'd0, 5'd0, 5'd3}; ic.st_data_ok = 3'b110;
    repeat (14) @(posedge clk);
    #1;
    n_cmp++; if (ic.stall_cnt !== 4'd14) begin n_err++; $display("FAIL t6_cnt14 got %0d want 14", ic.stall_cnt); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (ic.stall_cnt !== 4'd15) begin n_err++; $display("FAIL t6_saturate got %0d want 15", ic.stall_cnt); end
    @(negedge clk) ic.perf_clr = 1;
    @(posedge clk); #1;
    n_cmp++; if (ic.stall_cnt !== 4'd0) begin n_err++; $display("FAIL t6_clr_prio got %0d want 0", ic.stall_cnt); end
    @(negedge clk) ic.perf_clr = 0;
    @(posedge clk); #1;
    n_cmp++; if (ic.stall_cnt !== 4'd1) begin n_err++; $display("FAIL t6_after_clr got %0d want 1", ic.stall_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_forward_priority();
    test_load_use();
    test_zero_and_nofwd();
    test_div_stall();
    test_flush_and_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
